// File: rtl/calc_op_sequencer.sv
// Multi-cycle BCD calculator controller: one shared iterative datapath for
// add/sub/mul/div, then double-dabble conversion of the result to packed BCD.
module calc_op_sequencer #(
  parameter int W = 8
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] x_bin,
  input  logic [W-1:0] y_bin,
  output logic         busy,
  output logic         done,
  output logic [19:0]  result_bcd,
  output logic [W-1:0] rem_bin,
  output logic         neg,
  output logic         err
);

  localparam int ACC_W = 2 * W;
  localparam int BIN_W = 16;
  localparam int BCD_W = 20;
  localparam int DIGITS = BCD_W / 4;
  localparam logic [4:0] CALC_LAST = 5'(W - 1);
  localparam logic [4:0] CONV_LAST = 5'(BIN_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_CONV, S_DONE} state_e;
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [W-1:0]     x_q, x_d;
  logic [W-1:0]     y_q, y_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             neg_int_q, neg_int_d;
  logic             err_int_q, err_int_d;
  logic [BIN_W-1:0] sr_q, sr_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] res_q, res_d;
  logic [W-1:0]     rem_out_q, rem_out_d;
  logic             neg_out_q, neg_out_d;
  logic             err_out_q, err_out_d;

  logic             calc_last;
  logic             conv_last;
  logic [W:0]       sum_w;
  logic [W:0]       trial_w;
  logic             q_bit;
  logic [BCD_W-1:0] bcd_adj;

  // Add, sub and divide-by-zero finish in one CALC cycle; mul/div take W.
  assign calc_last = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                     ((op_q == OP_DIV) && (y_q == '0)) || (cnt_q == CALC_LAST);
  assign conv_last = (cnt_q == CONV_LAST);

  // ---------------------------------------------------------------- state register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of all others, independent of process ordering.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch.
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start)     state_d = S_CALC;
      S_CALC: if (calc_last) state_d = S_CONV;
      S_CONV: if (conv_last) state_d = S_DONE;
      S_DONE:                state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  assign result_bcd = res_q;
  assign rem_bin    = rem_out_q;
  assign neg        = neg_out_q;
  assign err        = err_out_q;

  // Double-dabble correction applied to every digit before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    op_d      = op_q;
    x_d       = x_q;
    y_d       = y_q;
    rem_d     = rem_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_int_d = neg_int_q;
    err_int_d = err_int_q;
    sr_d      = sr_q;
    bcd_d     = bcd_q;
    res_d     = res_q;
    rem_out_d = rem_out_q;
    neg_out_d = neg_out_q;
    err_out_d = err_out_q;
    sum_w     = '0;
    trial_w   = '0;
    q_bit     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = op_e'(op);
          x_d       = x_bin;
          y_d       = y_bin;
          cnt_d     = '0;
          rem_d     = '0;
          neg_int_d = 1'b0;
          err_int_d = 1'b0;
          // Multiply shifts the multiplier (Y) out of acc; divide shifts X.
          acc_d     = (op_e'(op) == OP_MUL) ? {{W{1'b0}}, y_bin} : {{W{1'b0}}, x_bin};
        end
      end

      S_CALC: begin
        cnt_d = cnt_q + 5'd1;
        case (op_q)
          OP_ADD: begin
            sum_w = {1'b0, x_q} + {1'b0, y_q};
            acc_d = ACC_W'(sum_w);
          end
          OP_SUB: begin
            if (x_q >= y_q) begin
              acc_d = ACC_W'(x_q - y_q);
            end else begin
              acc_d     = ACC_W'(y_q - x_q);
              neg_int_d = 1'b1;
            end
          end
          OP_MUL: begin
            // Upper half accumulates X when the current multiplier LSB is set.
            sum_w = {1'b0, acc_q[ACC_W-1:W]} + (acc_q[0] ? {1'b0, x_q} : '0);
            acc_d = {sum_w, acc_q[W-1:1]};
          end
          OP_DIV: begin
            if (y_q == '0) begin
              acc_d     = '0;
              rem_d     = '0;
              err_int_d = 1'b1;
            end else begin
              trial_w = {rem_q, acc_q[W-1]};
              if (trial_w >= {1'b0, y_q}) begin
                rem_d = W'(trial_w - {1'b0, y_q});
                q_bit = 1'b1;
              end else begin
                rem_d = trial_w[W-1:0];
              end
              acc_d = {acc_q[ACC_W-1:W], acc_q[W-2:0], q_bit};
            end
          end
          default: ;
        endcase
        if (calc_last) begin
          cnt_d = '0;
          sr_d  = BIN_W'(acc_d);
          bcd_d = '0;
        end
      end

      S_CONV: begin
        cnt_d         = cnt_q + 5'd1;
        {bcd_d, sr_d} = {bcd_adj[BCD_W-2:0], sr_q, 1'b0};
        if (conv_last) begin
          cnt_d     = '0;
          res_d     = bcd_d;
          rem_out_d = rem_q;
          neg_out_d = neg_int_q;
          err_out_d = err_int_q;
        end
      end

      default: ;
    endcase
  end

  // NOTE: every datapath flop is reset (there is no memory array here), so an
  // abandoned operation leaves no stale accumulator or output behind.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      op_q      <= OP_ADD;
      x_q       <= '0;
      y_q       <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_int_q <= 1'b0;
      err_int_q <= 1'b0;
      sr_q      <= '0;
      bcd_q     <= '0;
      res_q     <= '0;
      rem_out_q <= '0;
      neg_out_q <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rem_q     <= rem_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_int_q <= neg_int_d;
      err_int_q <= err_int_d;
      sr_q      <= sr_d;
      bcd_q     <= bcd_d;
      res_q     <= res_d;
      rem_out_q <= rem_out_d;
      neg_out_q <= neg_out_d;
      err_out_q <= err_out_d;
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: arithmetic reference model checked every cycle,
// directed cases with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_calc_op_sequencer;

  localparam int W         = 8;
  localparam int LAT_SHORT = 1 + 1 + 16;
  localparam int LAT_LONG  = 1 + W + 16;

  typedef struct packed {
    logic [19:0]  bcd;
    logic [W-1:0] rem;
    logic         neg;
    logic         err;
    logic [7:0]   lat;
  } exp_t;

  logic         CLOCK_50 = 1'b0;
  logic         reset    = 1'b1;
  logic         start    = 1'b0;
  logic [1:0]   op       = 2'b00;
  logic [W-1:0] x_bin    = '0;
  logic [W-1:0] y_bin    = '0;
  logic         busy, done, neg, err;
  logic [19:0]  result_bcd;
  logic [W-1:0] rem_bin;

  int n_checks = 0;
  int n_fail   = 0;

  calc_op_sequencer #(.W(W)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .x_bin     (x_bin),
    .y_bin     (y_bin),
    .busy      (busy),
    .done      (done),
    .result_bcd(result_bcd),
    .rem_bin   (rem_bin),
    .neg       (neg),
    .err       (err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] b = '0;
    for (int i = 0; i < 5; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  function automatic exp_t model_op(input logic [1:0] o, input int unsigned x, input int unsigned y);
    int unsigned r = 0;
    exp_t e = '0;
    e.lat = 8'(LAT_SHORT);
    case (o)
      2'd0: r = x + y;
      2'd1: if (x >= y) r = x - y; else begin r = y - x; e.neg = 1'b1; end
      2'd2: begin r = x * y; e.lat = 8'(LAT_LONG); end
      default: begin
        if (y == 0) e.err = 1'b1;
        else begin r = x / y; e.rem = W'(x % y); e.lat = 8'(LAT_LONG); end
      end
    endcase
    e.bcd = to_bcd(r);
    return e;
  endfunction

  // Reference model: m_k counts cycles since the accepted start (0 = idle).
  int   m_k     = 0;
  exp_t m_pend  = '0;
  exp_t m_shown = '0;

  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      m_k     <= 0;
      m_shown <= '0;
    end else if (m_k == 0) begin
      if (start) begin
        m_pend <= model_op(op, 32'(x_bin), 32'(y_bin));
        m_k    <= 1;
      end
    end else if (m_k == int'(m_pend.lat)) begin
      m_k <= 0;
    end else begin
      m_k <= m_k + 1;
      if (m_k + 1 == int'(m_pend.lat)) m_shown <= m_pend;
    end
  end

  always @(negedge CLOCK_50) begin
    check("busy", 32'(busy), 32'(m_k != 0));
    check("done", 32'(done), 32'((m_k != 0) && (m_k == int'(m_pend.lat))));
    check("result_bcd", 32'(result_bcd), 32'(m_shown.bcd));
    check("rem_bin", 32'(rem_bin), 32'(m_shown.rem));
    check("neg", 32'(neg), 32'(m_shown.neg));
    check("err", 32'(err), 32'(m_shown.err));
  end

  // Called at a falling edge; returns at the falling edge of the idle cycle
  // after done, so the next call starts back-to-back.
  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int lat, input logic [19:0] bcd,
                        input logic [W-1:0] rem, input logic n, input logic e);
    int cyc = 1;
    start = 1'b1; op = o; x_bin = x; y_bin = y;
    @(negedge CLOCK_50);
    start = 1'b0;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge CLOCK_50);
      cyc++;
    end
    check({name, " latency"}, 32'(cyc), 32'(lat));
    check({name, " bcd"}, 32'(result_bcd), 32'(bcd));
    check({name, " rem"}, 32'(rem_bin), 32'(rem));
    check({name, " neg"}, 32'(neg), 32'(n));
    check({name, " err"}, 32'(err), 32'(e));
    @(negedge CLOCK_50);
  endtask

  initial begin
    int pulses;
    int done_cyc;

    repeat (2) @(negedge CLOCK_50);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset bcd", 32'(result_bcd), 32'd0);
    reset = 1'b0;
    @(negedge CLOCK_50);

    run_op("add",      2'd0, 8'd123, 8'd45,  18, 20'h00168, 8'd0, 1'b0, 1'b0);
    run_op("sub_neg",  2'd1, 8'd45,  8'd123, 18, 20'h00078, 8'd0, 1'b1, 1'b0);
    run_op("sub_eq",   2'd1, 8'd50,  8'd50,  18, 20'h00000, 8'd0, 1'b0, 1'b0);
    run_op("mul",      2'd2, 8'd199, 8'd199, 25, 20'h39601, 8'd0, 1'b0, 1'b0);
    run_op("mul_zero", 2'd2, 8'd0,   8'd150, 25, 20'h00000, 8'd0, 1'b0, 1'b0);
    run_op("mul_full", 2'd2, 8'd255, 8'd255, 25, 20'h65025, 8'd0, 1'b0, 1'b0);
    run_op("add_full", 2'd0, 8'd255, 8'd255, 18, 20'h00510, 8'd0, 1'b0, 1'b0);
    run_op("div",      2'd3, 8'd199, 8'd7,   25, 20'h00028, 8'd3, 1'b0, 1'b0);
    run_op("div_zero", 2'd3, 8'd5,   8'd0,   18, 20'h00000, 8'd0, 1'b0, 1'b1);

    // Start and operand changes while busy must be ignored.
    start = 1'b1; op = 2'd2; x_bin = 8'd12; y_bin = 8'd12;
    @(negedge CLOCK_50);
    pulses = 0;
    done_cyc = 0;
    for (int c = 1; c <= 60; c++) begin
      if (done === 1'b1) begin
        pulses++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (c == 12) begin
        start = 1'b1; op = 2'd0; x_bin = 8'd99;
      end else begin
        start = 1'b0;
      end
      @(negedge CLOCK_50);
    end
    check("ignore pulses", 32'(pulses), 32'd1);
    check("ignore latency", 32'(done_cyc), 32'd25);
    check("ignore bcd", 32'(result_bcd), 32'h00144);

    // Reset mid-division: everything clears at once and no done follows.
    start = 1'b1; op = 2'd3; x_bin = 8'd199; y_bin = 8'd7;
    @(negedge CLOCK_50);
    start = 1'b0;
    repeat (9) @(negedge CLOCK_50);
    #2 reset = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort bcd", 32'(result_bcd), 32'd0);
    check("abort rem", 32'(rem_bin), 32'd0);
    check("abort neg", 32'(neg), 32'd0);
    check("abort err", 32'(err), 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLOCK_50);
      if (done === 1'b1) pulses++;
    end
    check("abort no done", 32'(pulses), 32'd0);
    run_op("post_reset", 2'd0, 8'd1, 8'd1, 18, 20'h00002, 8'd0, 1'b0, 1'b0);

    // Randomized traffic, including start during busy/DONE and rare resets.
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 2) == 0);
      op    = 2'($urandom);
      x_bin = W'($urandom);
      y_bin = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
      reset = ($urandom_range(0, 999) == 0);
      @(negedge CLOCK_50);
    end
    start = 1'b0;
    reset = 1'b0;
    repeat (30) @(negedge CLOCK_50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
Multi-cycle controller for the switch-driven BCD calculator. It latches two binary operands and an operation code on a start pulse, then runs one shared iterative datapath: a single-cycle add/subtract, shift-add multiply or restoring divide. It then converts the result to packed BCD by iterative double-dabble and presents it with a done pulse. The top level feeds it from the existing bcd2bin converters and sends result_bcd to the hex encoders. This replaces the parallel adder, multiplier and divider instances.

Parameters:
W, 8, operand width in bits. Legal range 4..8, so the 2W-bit result always fits in 5 BCD digits.

Ports:
CLOCK_50  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  2  operation: 00 add, 01 sub, 10 mul, 11 div
x_bin  in  W  operand X, unsigned binary
y_bin  in  W  operand Y, unsigned binary
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse; outputs valid from this cycle
result_bcd  out  20  packed 5-digit BCD magnitude of the result
rem_bin  out  W  division remainder, binary; 0 for other ops
neg  out  1  subtract result negative (X < Y)
err  out  1  divide by zero

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE.
  - busy, done, neg and err are 0.
  - result_bcd and rem_bin are 0.
  - All internal accumulators and counters are cleared.
  - Any operation in progress is abandoned; no done pulse is produced.
- FSM states: IDLE, CALC, CONV, DONE.
- IDLE:
  - On a clock edge with start=1, latch x_bin, y_bin and op, clear the iteration counter, and go to CALC.
  - start=0: stay in IDLE.
- CALC, add: acc = X+Y (W+1 bits, no overflow). 1 cycle, then CONV.
- CALC, sub:
  - X>=Y: acc = X-Y, neg_int = 0.
  - X<Y: acc = Y-X, neg_int = 1.
  - 1 cycle, then CONV.
- CALC, mul:
  - Shift-add, LSB of multiplier first, one bit per cycle.
  - W cycles; acc is the 2W-bit product. Then CONV.
- CALC, div:
  - Restoring division, MSB first, one quotient bit per cycle.
  - W cycles; acc = quotient, rem_int = remainder. Then CONV.
- CALC, div with Y=0:
  - 1 cycle; acc = 0, rem_int = 0, err_int = 1. Then CONV.
- CONV:
  - Double-dabble on the 2W-bit acc zero-extended to 16 bits.
  - 16 shift cycles. Before each shift, add 3 to any BCD digit >= 5. Then DONE.
- DONE (exactly one cycle):
  - done=1.
  - result_bcd, rem_bin, neg and err are loaded from internal registers at entry to DONE.
  - These outputs then hold until the next entry to DONE or reset.
  - Next state is IDLE.
- Latency from the start-sampling edge to the cycle with done=1:
  - Formula: 1 + C + 16, where C = 1 for add, sub and div-by-zero, and C = W for mul and div.
  - W=8: add/sub = 18 cycles; mul/div = 25 cycles.
- busy = 1 in CALC, CONV and DONE.
- start asserted while busy (including the DONE cycle) is ignored: not queued, no effect on the operation in progress.
- Operands and op are latched once at start. Changes to x_bin, y_bin or op mid-operation have no effect.
- neg is 1 only for sub with X<Y. err is 1 only for div with Y=0. Both are 0 for all other cases.
- rem_bin is 0 for add, sub and mul.
- Back-to-back operation: start sampled in the IDLE cycle right after DONE is accepted. Minimum spacing between done pulses = latency + 1.

Test Plan:
- add, X=123, Y=45, one-cycle start -> done 18 cycles after the start edge. result_bcd=20'h00168, neg=0, err=0, rem_bin=0.
- sub, X=45, Y=123 -> result_bcd=20'h00078, neg=1. Then sub, X=50, Y=50 -> result_bcd=0, neg=0.
- mul, X=199, Y=199 -> done at 25 cycles. result_bcd=20'h39601. Also mul, X=0, Y=150 -> result_bcd=0.
- div, X=199, Y=7 -> result_bcd=20'h00028, rem_bin=3, err=0, latency 25. div, X=5, Y=0 -> err=1, result_bcd=0, rem_bin=0, latency 18.
- Start mul 12x12. Pulse start with op=add and change x_bin during CONV -> ignored; result_bcd=20'h00144, exactly one done pulse.
- Start div 199/7. Assert reset in cycle 10 -> busy=0, done=0, all outputs 0 immediately. No done pulse. A fresh add 1+1 afterwards gives 20'h00002.
